// File: rtl/ysyx_23060203_ifu_fetch.sv
// Instruction fetch unit: issues one word read at a time, buffers the returned
// instruction for decode, predicts the next PC (backward branches taken) and
// handles backend/decode redirects, including dropping an in-flight response.
module ysyx_23060203_ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h3000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        flush,
  input  logic [31:0] flush_dnpc,
  input  logic        jump_flush,
  input  logic [31:0] jump_dnpc,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst
);

  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [1:0]  state, state_n;
  logic [31:0] fetch_pc, fetch_pc_n;
  logic [31:0] next_pc, next_pc_n;
  logic        drop, drop_n;
  logic [31:0] out_pc_n, out_inst_n;

  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] imm_b;
  logic [31:0] pred_pc;

  // Redirect selection and static prediction of the returned instruction
  always_comb begin
    redirect    = flush | jump_flush;
    redirect_pc = flush ? flush_dnpc : jump_dnpc;
    imm_b       = {{20{mem_resp_data[31]}}, mem_resp_data[7],
                   mem_resp_data[30:25], mem_resp_data[11:8], 1'b0};
    if ((mem_resp_data[6:2] == 5'b11000) && mem_resp_data[31])
      pred_pc = fetch_pc + imm_b;
    else
      pred_pc = fetch_pc + 32'd4;
  end

  // Next-state logic; a redirect always retargets fetch_pc
  always_comb begin
    state_n    = state;
    fetch_pc_n = fetch_pc;
    next_pc_n  = next_pc;
    drop_n     = drop;
    out_pc_n   = out_pc;
    out_inst_n = out_inst;
    case (state)
      S_REQ: begin
        if (redirect) fetch_pc_n = redirect_pc;
        if (mem_req_ready) begin
          state_n = S_WAIT;
          drop_n  = redirect;
        end
      end
      S_WAIT: begin
        if (redirect) begin
          fetch_pc_n = redirect_pc;
          if (mem_resp_valid) begin
            state_n = S_REQ;
            drop_n  = 1'b0;
          end else begin
            drop_n  = 1'b1;
          end
        end else if (mem_resp_valid) begin
          if (drop) begin
            state_n = S_REQ;
            drop_n  = 1'b0;
          end else begin
            state_n    = S_HOLD;
            out_pc_n   = fetch_pc;
            out_inst_n = mem_resp_data;
            next_pc_n  = pred_pc;
          end
        end
      end
      S_HOLD: begin
        if (redirect) begin
          fetch_pc_n = redirect_pc;
          state_n    = S_REQ;
        end else if (out_ready) begin
          fetch_pc_n = next_pc;
          state_n    = S_REQ;
        end
      end
      default: state_n = S_REQ;
    endcase
  end

  // State and datapath registers, synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_REQ;
      fetch_pc <= RESET_PC;
      next_pc  <= 32'd0;
      drop     <= 1'b0;
      out_pc   <= 32'd0;
      out_inst <= 32'd0;
    end else begin
      state    <= state_n;
      fetch_pc <= fetch_pc_n;
      next_pc  <= next_pc_n;
      drop     <= drop_n;
      out_pc   <= out_pc_n;
      out_inst <= out_inst_n;
    end
  end

  // Handshake outputs decode the state; masked while reset is held so the
  // first request appears in the first cycle after release
  always_comb begin
    mem_req_valid = (state == S_REQ) & ~reset;
    out_valid     = (state == S_HOLD) & ~reset;
    mem_req_addr  = fetch_pc;
  end

endmodule

// File: doc/ysyx_23060203_ifu_fetch.md
YSYX_23060203_IFU_FETCH -- requirements
Module: ysyx_23060203_ifu_fetch

Interface
REQ-001 Parameter: RESET_PC, default 32'h3000_0000, first fetch address after reset.
REQ-002 clock  input  1  system clock.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 flush  input  1  backend redirect (exception, mret, fence.i); highest priority.
REQ-005 flush_dnpc  input  32  target PC for flush.
REQ-006 jump_flush  input  1  decode-stage misprediction redirect.
REQ-007 jump_dnpc  input  32  target PC for jump_flush.
REQ-008 mem_req_valid  output  1  instruction read request.
REQ-009 mem_req_ready  input  1  memory accepts request.
REQ-010 mem_req_addr  output  32  word address of request, equal to fetch_pc.
REQ-011 mem_resp_valid  input  1  read data valid; the block always accepts it; no ready signal.
REQ-012 mem_resp_data  input  32  fetched instruction word.
REQ-013 out_valid  output  1  instruction available to decode.
REQ-014 out_ready  input  1  decode accepts instruction.
REQ-015 out_pc  output  32  PC of out_inst.
REQ-016 out_inst  output  32  instruction word.

Function
REQ-017 States: REQ (drive request), WAIT (request accepted, awaiting response), HOLD (instruction buffered, out_valid=1).
REQ-018 mem_req_valid SHALL be 1 only in REQ; out_valid SHALL be 1 only in HOLD.
REQ-019 In REQ: mem_req_addr=fetch_pc; if mem_req_ready=1, go to WAIT next cycle; otherwise stay. Changing the address before acceptance is permitted on this port.
REQ-020 In WAIT: if mem_resp_valid=1 and drop=0, latch out_pc=fetch_pc and out_inst=mem_resp_data, compute next_pc, and go to HOLD.
REQ-021 Prediction for next_pc, computed at response capture:
- opcode[6:2]=5'b11000 (BRANCH) and inst[31]=1: next_pc = pc + sext(imm_b).
- All other cases, including JAL and JALR: next_pc = pc + 4.
- Arithmetic is 32-bit modulo 2^32; wrap-around is permitted.
REQ-022 In HOLD: if out_ready=1, set fetch_pc=next_pc and go to REQ next cycle.
REQ-023 Latency: acceptance at cycle t with response at t+1 gives out_valid at t+2; an out handshake at t+2 gives mem_req_valid at t+3.
REQ-024 Redirect: redirect = flush | jump_flush. Target = flush_dnpc if flush=1, else jump_dnpc. Redirect applies in any state and sets fetch_pc to the target next cycle.
REQ-025 Redirect in HOLD: the buffered instruction is discarded; out_valid=0 next cycle; state goes to REQ. This holds even if out_ready=1 in the same cycle; decode ignores an instruction accepted under flush.
REQ-026 Redirect in REQ, request not accepted that cycle: stay in REQ with the new address.
REQ-027 Redirect in REQ with mem_req_ready=1 that cycle: go to WAIT with drop=1.
REQ-028 Redirect in WAIT with no response that cycle: stay in WAIT and set drop=1.
REQ-029 Redirect in WAIT with a response that cycle: discard the response; go to REQ with drop=0.
REQ-030 In WAIT with drop=1: on mem_resp_valid, discard the data, clear drop, and go to REQ using the redirected fetch_pc.
REQ-031 Multiple redirects before a dropped response returns: the latest target wins, and only one response is dropped (at most one outstanding request).
REQ-032 Addresses are used unmodified; mem_req_addr[1:0] passes through as is.
REQ-033 mem_resp_valid in REQ or HOLD is a protocol error and SHALL be ignored.

Reset
REQ-034 While reset=1: state=REQ, fetch_pc=RESET_PC, drop=0, mem_req_valid=0, out_valid=0, out_pc=0, out_inst=0.
REQ-035 First cycle after reset deasserts: mem_req_valid=1, mem_req_addr=RESET_PC.
REQ-036 Reset asserted mid-transaction (WAIT or HOLD) SHALL abandon it; any later response SHALL be ignored until a new request is accepted.

Verification
REQ-037 Reset release, mem_req_ready=1, 1-cycle response 32'h00000013: req addr 32'h3000_0000; out_valid 2 cycles after acceptance with out_pc=32'h3000_0000; next req addr 32'h3000_0004.
REQ-038 Branch response 32'hFE000EE3 (beq x0,x0,-4) at pc 32'h3000_0010: next mem_req_addr=32'h3000_000C. The same encoding with inst[31]=0 (beq, +offset) gives next addr = pc+imm_b? No, pc+4: forward branches go to 32'h3000_0014.
REQ-039 jump_flush=1, jump_dnpc=32'h3000_0100 while in WAIT; the response arrives 3 cycles later: the response is dropped, out_valid stays 0, next req addr=32'h3000_0100.
REQ-040 flush=1 (flush_dnpc=32'h3000_0200) and jump_flush=1 (jump_dnpc=32'h3000_0300) in the same cycle: the next request goes to 32'h3000_0200.
REQ-041 HOLD with out_ready=0 for 5 cycles: out_pc and out_inst stay stable and no request is issued. A redirect in cycle 3 clears out_valid next cycle and issues a request to the target.
REQ-042 pc=32'hFFFF_FFFC, non-branch: next req addr=32'h0000_0000.
